pattern_scan_ctrl: RTL



---
 rtl/pattern_scan_ctrl_if.sv | 27 ++
 rtl/pattern_scan_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// Word-in / result-out handshake bundle for pattern_scan_ctrl.
interface pattern_scan_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_restart;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] first_pos;
  logic             det_out;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_restart, out_ready,
    input  in_ready, out_valid, match_count, first_pos, det_out
  );

  // Scanner side
  modport slave (
    input  in_valid, in_data, in_restart, out_ready,
    output in_ready, out_valid, match_count, first_pos, det_out
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Scans a word MSB-first through an overlapping 1101 Moore detector and
// reports the match count and the position of the first match.
module pattern_scan_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  pattern_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DRAIN, ST_DONE} state_e;
  typedef enum logic [2:0] {D_S0, D_S1, D_S11, D_S110, D_S1101} det_e;

  localparam int unsigned LAST_POS = WIDTH - 1;

  state_e           state_q, state_d;
  det_e             det_q, det_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fp_q, fp_d;
  logic             in_ready_q, out_valid_q, det_out_q;
  logic             score_c;

  // Overlapping 1101 detector transition table
  function automatic det_e det_next(input det_e s, input logic b);
    case (s)
      D_S0:    return b ? D_S1    : D_S0;
      D_S1:    return b ? D_S11   : D_S0;
      D_S11:   return b ? D_S11   : D_S110;
      D_S110:  return b ? D_S1101 : D_S0;
      D_S1101: return b ? D_S11   : D_S0;
      default: return D_S0;
    endcase
  endfunction

  // A match is scored when the detector sits in S1101 because of a bit of
  // this word; the first SHIFT cycle only shows carry-in from the last word.
  always_comb begin
    score_c = 1'b0;
    if (det_q == D_S1101) begin
      if (state_q == ST_DRAIN) score_c = 1'b1;
      if (state_q == ST_SHIFT && idx_q != '0) score_c = 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fp_d    = fp_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.in_data;
          idx_d   = '0;
          cnt_d   = '0;
          fp_d    = '0;
          if (bus.in_restart) det_d = D_S0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_d = det_next(det_q, sr_q[WIDTH-1]);
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == CNT_W'(LAST_POS)) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (score_c) begin
      if (cnt_q == '0) fp_d = idx_q - CNT_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, datapath and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      det_q       <= D_S0;
      sr_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      fp_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      det_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fp_q        <= fp_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      det_out_q   <= (det_d == D_S1101);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.match_count = cnt_q;
  assign bus.first_pos   = fp_q;
  assign bus.det_out     = det_out_q;

endmodule
